// File: rtl/rr_port_arbiter.sv
// Round-robin port arbiter: grants one requester at a time, forwards the owner's
// beats, and bounds each ownership to MAX_HOLD cycles with an idle gap between owners.
module rr_port_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_last,
  input  logic [N_REQ*DATA_W-1:0]   i_data,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [$clog2(N_REQ)-1:0]  o_owner,
  output logic                      o_busy,
  output logic                      o_valid,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_timeout
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  generate
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
      $error("rr_port_arbiter: N_REQ must be in 2..16");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_port_arbiter: MAX_HOLD must be in 1..255");
    end
  endgenerate

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state_p1;
  logic [IDX_W-1:0]    ptr_p1;
  logic [IDX_W-1:0]    owner_p1;
  logic [HOLD_W-1:0]   hold_cnt_p1;
  logic [N_REQ-1:0]    gnt_p1;
  logic                vld_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                timeout_p1;

  logic [IDX_W-1:0]    pick;
  logic                owner_req;
  logic                owner_rel;
  logic                hit_max;
  logic                own_exit;
  logic [DATA_W-1:0]   owner_data;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Scan from ptr upward; iterating from the far end lets the nearest hit win.
  always_comb begin
    int s;
    pick = ptr_p1;
    s    = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      s = int'(ptr_p1) + i;
      if (s >= N_REQ) s = s - N_REQ;
      if (i_req[s]) pick = IDX_W'(s);
    end
  end

  always_comb begin
    owner_req  = i_req[owner_p1];
    owner_rel  = owner_req && i_last[owner_p1];
    hit_max    = (hold_cnt_p1 == HOLD_W'(MAX_HOLD - 1));
    own_exit   = !owner_req || owner_rel || hit_max;
    owner_data = i_data[int'(owner_p1)*DATA_W +: DATA_W];
  end

  // Stage p1: arbitration state and registered outputs
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_p1    <= IDLE;
      ptr_p1      <= '0;
      owner_p1    <= '0;
      hold_cnt_p1 <= '0;
      gnt_p1      <= '0;
      vld_p1      <= 1'b0;
      data_p1     <= '0;
      timeout_p1  <= 1'b0;
    end else begin
      vld_p1     <= 1'b0;
      timeout_p1 <= 1'b0;
      case (state_p1)
        IDLE: begin
          if (|i_req) begin
            state_p1    <= OWN;
            gnt_p1      <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
            owner_p1    <= pick;
            hold_cnt_p1 <= '0;
            ptr_p1      <= wrap_inc(pick);
          end
        end
        OWN: begin
          if (owner_req) begin
            vld_p1  <= 1'b1;
            data_p1 <= owner_data;
          end
          if (hold_cnt_p1 != HOLD_W'(MAX_HOLD)) hold_cnt_p1 <= hold_cnt_p1 + 1'b1;
          // A last beat landing on the hold limit is a normal release, not a timeout.
          if (own_exit) begin
            state_p1   <= IDLE;
            gnt_p1     <= '0;
            timeout_p1 <= hit_max && !owner_rel;
          end
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

  assign o_gnt     = gnt_p1;
  assign o_owner   = owner_p1;
  assign o_busy    = |gnt_p1;
  assign o_valid   = vld_p1;
  assign o_data    = data_p1;
  assign o_timeout = timeout_p1;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Bench for rr_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the grant/release rules.
module tb_rr_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MH = 8;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      last = '0;
  logic [N*DW-1:0]   data = '0;
  logic [N-1:0]      gnt;
  logic [1:0]        owner;
  logic              busy;
  logic              valid;
  logic [DW-1:0]     dout;
  logic              timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ownership flag, owner, granted-cycle count, next search start.
  bit       m_on;
  int       m_owner;
  int       m_cycles;
  int       m_ptr;
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_timeout;

  rr_port_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .i_clk    (clk),
    .i_arst   (arst),
    .i_req    (req),
    .i_last   (last),
    .i_data   (data),
    .o_gnt    (gnt),
    .o_owner  (owner),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_data   (dout),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_owner = 0; m_cycles = 0; m_ptr = 0;
    m_valid = 0; m_data = 0; m_timeout = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*DW-1:0] d);
    bit rq, rel, hit;
    m_valid = 0;
    m_timeout = 0;
    if (!m_on) begin
      for (int i = 0; i < N; i++) begin
        if (r[(m_ptr + i) % N]) begin
          m_owner  = (m_ptr + i) % N;
          m_on     = 1;
          m_cycles = 0;
          m_ptr    = (m_owner + 1) % N;
          break;
        end
      end
    end else begin
      m_cycles++;
      rq  = r[m_owner];
      rel = rq && l[m_owner];
      hit = (m_cycles == MH);
      if (rq) begin
        m_valid = 1;
        m_data  = d[m_owner*DW +: DW];
      end
      if (!rq || rel || hit) begin
        m_on      = 0;
        m_timeout = hit && !rel;
      end
    end
  endtask

  task automatic compare_model();
    check_eq("gnt",     gnt,     m_on ? (32'd1 << m_owner) : 32'd0);
    check_eq("owner",   owner,   m_owner);
    check_eq("busy",    busy,    m_on);
    check_eq("valid",   valid,   m_valid);
    check_eq("data",    dout,    m_data);
    check_eq("timeout", timeout, m_timeout);
  endtask

  // Called #1 after an active edge; drives inputs, advances model, checks after next edge.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*DW-1:0] d);
    req = r; last = l; data = d;
    model_step(r, l, d);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    req = '0; last = '0; data = '0;
    @(posedge clk);
    #1;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_owner", owner, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_data", dout, 0);
    check_eq("rst_timeout", timeout, 0);
    arst = 1'b0;
    model_reset();
  endtask

  initial begin
    int hi;
    bit to_at_fall;
    logic [N-1:0] prev_gnt;
    int seq[$];
    logic [N-1:0] r, l;

    model_reset();
    #1;
    do_reset();

    // Single request on port 2
    cycle(4'b0100, 4'b0000, 32'h00A5_0000);
    check_eq("single_gnt", gnt, 4'b0100);
    check_eq("single_owner", owner, 2);
    cycle(4'b0100, 4'b0000, 32'h00A5_0000);
    check_eq("single_valid", valid, 1);
    check_eq("single_data", dout, 8'hA5);
    cycle(4'b0000, 4'b0000, 32'h0);

    // Round robin with last on each owner's second beat
    do_reset();
    prev_gnt = '0;
    for (int i = 0; i < 20 && seq.size() < 5; i++) begin
      l = (m_on && m_cycles == 1) ? 4'b1111 : 4'b0000;
      cycle(4'b1111, l, $urandom);
      if (gnt != 0 && prev_gnt == 0) seq.push_back(int'(owner));
      prev_gnt = gnt;
    end
    check_eq("rr_count", seq.size(), 5);
    for (int i = 0; i < seq.size(); i++) check_eq("rr_seq", seq[i], i % N);

    // Timeout with a lone requester
    do_reset();
    hi = 0; to_at_fall = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0001, 4'b0000, $urandom);
      if (gnt == 4'b0001) hi++;
      else if (hi > 0) begin
        to_at_fall = timeout;
        break;
      end
    end
    check_eq("to_len", hi, MH);
    check_eq("to_pulse", to_at_fall, 1);
    cycle(4'b0001, 4'b0000, $urandom);
    check_eq("to_regrant", gnt, 4'b0001);
    check_eq("to_once", timeout, 0);

    // Last on the final allowed cycle is a normal release
    do_reset();
    hi = 0; to_at_fall = 1;
    for (int i = 0; i < 20; i++) begin
      l = (m_on && m_cycles == MH - 1) ? 4'b0001 : 4'b0000;
      cycle(4'b0001, l, $urandom);
      if (gnt == 4'b0001) hi++;
      else if (hi > 0) begin
        to_at_fall = timeout;
        break;
      end
    end
    check_eq("last8_len", hi, MH);
    check_eq("last8_timeout", to_at_fall, 0);

    // Owner 1 drops its request in its third grant cycle
    do_reset();
    cycle(4'b0010, 4'b0000, 32'h0000_3300);
    check_eq("drop_gnt", gnt, 4'b0010);
    cycle(4'b0010, 4'b0000, 32'h0000_3300);
    cycle(4'b0010, 4'b0000, 32'h0000_3300);
    cycle(4'b0000, 4'b0000, 32'h0000_3300);
    check_eq("drop_valid", valid, 0);
    check_eq("drop_release", gnt, 4'b0000);
    cycle(4'b1111, 4'b0000, 32'h0);
    check_eq("drop_ptr_next", gnt, 4'b0100);

    // Asynchronous reset while port 3 owns the bus
    do_reset();
    cycle(4'b1000, 4'b0000, 32'h0);
    check_eq("ar_gnt", gnt, 4'b1000);
    #2;
    arst = 1'b1;
    #1;
    check_eq("ar_drop_gnt", gnt, 4'b0000);
    check_eq("ar_drop_busy", busy, 0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();
    cycle(4'b1001, 4'b0000, 32'h0);
    check_eq("ar_restart", gnt, 4'b0001);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      for (int b = 0; b < N; b++) begin
        r[b] = ($urandom_range(0, 3) != 0);
        l[b] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 7) == 0) r = '0;
      cycle(r, l, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_port_arbiter.md
RR_PORT_ARBITER -- requirements
Module: rr_port_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters; legal range 2..16, other values SHALL fail elaboration.
REQ-002 Parameter DATA_W, default 8, SHALL set the width of each requester's data word.
REQ-003 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive grant cycles per ownership; legal range 1..255.
REQ-004 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 i_arst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 i_req  input  N_REQ  SHALL carry the per-requester request, bit k = requester k.
REQ-007 i_last  input  N_REQ  SHALL mark requester k's final beat of the current ownership.
REQ-008 i_data  input  N_REQ*DATA_W  SHALL carry requester k's word in bits [k*DATA_W +: DATA_W].
REQ-009 o_gnt  output  N_REQ  SHALL be the registered, one-hot-or-zero grant.
REQ-010 o_owner  output  clog2(N_REQ)  SHALL hold the index of the current or last granted requester.
REQ-011 o_busy  output  1  SHALL be high while any o_gnt bit is high.
REQ-012 o_valid  output  1  SHALL be high for one cycle after each accepted beat.
REQ-013 o_data  output  DATA_W  SHALL hold the most recently accepted beat.
REQ-014 o_timeout  output  1  SHALL pulse for one cycle when an ownership is force-released by MAX_HOLD.

Function
REQ-015 The FSM SHALL have two states, IDLE and OWN.
REQ-016 In IDLE with i_req nonzero, the block SHALL search from pointer ptr upward modulo N_REQ and select the first set bit k.
REQ-017 At the next edge it SHALL enter OWN, set o_gnt to one-hot k and o_owner to k, clear hold_cnt to 0, and set ptr to (k+1) mod N_REQ.
REQ-018 Latency from i_req sampled high in IDLE to o_gnt high SHALL be exactly 1 cycle.
REQ-019 In IDLE with i_req zero, the block SHALL stay in IDLE and leave ptr unchanged.
REQ-020 In OWN, a beat SHALL be accepted in each cycle where i_req[owner] is high.
REQ-021 For each accepted beat, at the next edge o_data SHALL take the owner's slice and o_valid SHALL be 1; otherwise o_valid SHALL be 0 and o_data SHALL hold.
REQ-022 hold_cnt SHALL increment once per OWN cycle, saturating at MAX_HOLD.
REQ-023 OWN SHALL exit to IDLE at the edge ending a cycle in which any of the following holds: (a) i_req[owner] and i_last[owner]; (b) i_req[owner] low; (c) hold_cnt == MAX_HOLD-1.
REQ-024 On exit, o_gnt SHALL be 0 for at least one cycle, so there is one mandatory idle cycle between ownerships.
REQ-025 o_timeout SHALL pulse only for exit reason (c) when (a) is not also true; if (a) and (c) coincide, the exit SHALL count as a normal release with no timeout.
REQ-026 A beat in the exit cycle SHALL still be accepted if i_req[owner] is high.
REQ-027 Requests from non-owners SHALL be ignored in OWN; i_last SHALL be ignored for non-owners and in IDLE.
REQ-028 Fairness: with all requests held high, grants SHALL rotate 0,1,...,N_REQ-1,0, and no requester SHALL wait more than (N_REQ-1)*(MAX_HOLD+1) cycles.
REQ-029 ptr wrap SHALL be modulo N_REQ for non-power-of-two N_REQ; owner N_REQ-1 SHALL set ptr to 0.

Reset
REQ-030 While i_arst is high, the outputs SHALL be held: o_gnt=0, o_owner=0, o_busy=0, o_valid=0, o_data=0, o_timeout=0.
REQ-031 While i_arst is high, internal state SHALL be held: state=IDLE, ptr=0, hold_cnt=0.
REQ-032 Assertion of i_arst mid-ownership SHALL drop o_gnt immediately, without waiting for a clock edge.
REQ-033 After deassertion, arbitration SHALL restart from ptr=0.

Verification (N_REQ=4, DATA_W=8, MAX_HOLD=8)
REQ-034 Single request: i_req=4'b0100, i_data slice2=8'hA5 -> o_gnt=4'b0100 at the 1st edge; o_valid=1, o_data=8'hA5 at the 2nd edge; o_owner=2.
REQ-035 Round robin: i_req=4'b1111 held, i_last pulsed on each owner's 2nd beat -> owner sequence 0,1,2,3,0, with a 1-cycle gap of o_gnt=0 between ownerships.
REQ-036 Timeout: i_req=4'b0001 held, i_last=0 -> o_gnt high for exactly 8 cycles; o_timeout=1 for one cycle; re-grant to 0 after 1 idle cycle, since no other requester is active.
REQ-037 Last on 8th cycle: as REQ-036 but i_last[0]=1 in the 8th cycle -> release with o_timeout=0.
REQ-038 Drop request: owner 1 deasserts i_req in its 3rd grant cycle -> o_valid=0 that cycle; o_gnt=0 next cycle; ptr=2.
REQ-039 Reset mid-ownership: i_arst pulsed between edges while o_gnt=4'b1000 -> o_gnt=0 before the next edge; with i_req=4'b1001 after release, requester 0 is granted first.
